// File: rtl/ah_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ah_arb_pkg
//  Description : Shared defaults and derived widths for the arbitrated
//                requester: client count, payload width, queue depth,
//                client-index width and occupancy-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package ah_arb_pkg;

    localparam int DEF_NUM_CLIENTS = 4;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_DEPTH       = 4;

    // Width of an index that can name every value in [0, n-1], never below 1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_ID_W  = idx_width(DEF_NUM_CLIENTS);
    // One extra bit so a full queue (count == DEPTH) differs from an empty one.
    localparam int DEF_CNT_W = $clog2(DEF_DEPTH) + 1;

endpackage : ah_arb_pkg
`default_nettype wire

// File: rtl/ah_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ah_sync_fifo
//  Description : Single-clock FIFO with DEPTH entries (power of two, >= 2).
//                Full/empty/count are decoded from registered state only.
//  Ports       : clk, rst_n       - clock, async active-low reset
//                push_i, push_data_i - write strobe and data (ignored if full)
//                pop_i            - read strobe (ignored if empty)
//                full_o, empty_o  - status flags
//                count_o          - occupancy, $clog2(DEPTH)+1 bits
//                head_o           - oldest entry (valid when not empty)
//  Revision    : 1.0 - initial release
// ============================================================================
module ah_sync_fifo
    import ah_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push_i,
    input  logic [DATA_W-1:0]       push_data_i,
    input  logic                    pop_i,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic [DATA_W-1:0]       head_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              w_push;
    logic              w_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign w_push = push_i & ~full_o;
    assign w_pop  = pop_i  & ~empty_o;

    // Pointers are PTR_W bits wide with DEPTH a power of two, so the plain
    // increment wraps modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule : ah_sync_fifo
`default_nettype wire

// File: rtl/ah_arb_requester.sv
`default_nettype none
// ============================================================================
//  Module      : ah_arb_requester
//  Description : Per-client command queues feeding a round-robin arbiter.
//                Requests reflect non-empty queues; a legal one-hot grant
//                pops that client's head and issues it one cycle later.
//                Illegal grants are flagged in sticky error bits.
//  Ports       : clk, rst_n     - clock, async active-low reset
//                in_valid/in_ready/in_data - per-client push handshake
//                req            - per-client request (queue non-empty)
//                gnt            - registered grant from the arbiter
//                out_valid/out_id/out_data - registered issued command
//                err_spurious   - sticky: grant to a non-requesting client
//                err_multi      - sticky: grant with more than one bit set
//                clr_err        - synchronous clear of both error flags
//  Revision    : 1.0 - initial release
// ============================================================================
module ah_arb_requester
    import ah_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = DEF_NUM_CLIENTS,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH       = DEF_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_CLIENTS-1:0]           in_valid,
    output logic [NUM_CLIENTS-1:0]           in_ready,
    input  logic [NUM_CLIENTS*DATA_W-1:0]    in_data,
    output logic [NUM_CLIENTS-1:0]           req,
    input  logic [NUM_CLIENTS-1:0]           gnt,
    output logic                             out_valid,
    output logic [idx_width(NUM_CLIENTS)-1:0] out_id,
    output logic [DATA_W-1:0]                out_data,
    output logic                             err_spurious,
    output logic                             err_multi,
    input  logic                             clr_err
);

    localparam int ID_W  = idx_width(NUM_CLIENTS);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [NUM_CLIENTS-1:0]        w_full;
    logic [NUM_CLIENTS-1:0]        w_empty;
    logic [NUM_CLIENTS-1:0]        w_pop;
    logic [NUM_CLIENTS*DATA_W-1:0] w_heads;
    logic [NUM_CLIENTS*CNT_W-1:0]  w_counts;

    logic                          w_multi_hot;
    logic                          w_spurious;
    logic                          w_pop_any;
    logic [ID_W-1:0]               w_pop_id;
    logic [DATA_W-1:0]             w_pop_data;

    logic                          out_valid_q, out_valid_d;
    logic [ID_W-1:0]               out_id_q,    out_id_d;
    logic [DATA_W-1:0]             out_data_q,  out_data_d;
    logic                          err_spur_q,  err_spur_d;
    logic                          err_multi_q, err_multi_d;

    // ---------------------------------------------------------------------
    //  Per-client queues
    // ---------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
        ah_sync_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk         (clk),
            .rst_n       (rst_n),
            .push_i      (in_valid[gi] & in_ready[gi]),
            .push_data_i (in_data[gi*DATA_W +: DATA_W]),
            .pop_i       (w_pop[gi]),
            .full_o      (w_full[gi]),
            .empty_o     (w_empty[gi]),
            .count_o     (w_counts[gi*CNT_W +: CNT_W]),
            .head_o      (w_heads[gi*DATA_W +: DATA_W])
        );
    end : g_client

    // Both vectors come straight from FIFO registers; gnt never reaches them.
    assign in_ready = ~w_full;
    assign req      = ~w_empty;

    // ---------------------------------------------------------------------
    //  Grant check and pop select
    // ---------------------------------------------------------------------
    // x & (x-1) clears the lowest set bit; anything left means multi-hot.
    assign w_multi_hot = |(gnt & (gnt - NUM_CLIENTS'(1)));
    assign w_spurious  = |(gnt & ~req);

    // A pop needs a clean one-hot grant landing on a requesting client.
    assign w_pop     = (w_multi_hot || w_spurious) ? '0 : (gnt & req);
    assign w_pop_any = |w_pop;

    always_comb begin
        w_pop_id   = '0;
        w_pop_data = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (w_pop[i]) begin
                w_pop_id   = ID_W'(i);
                w_pop_data = w_heads[i*DATA_W +: DATA_W];
            end
        end
    end

    // ---------------------------------------------------------------------
    //  Output and error registers
    // ---------------------------------------------------------------------
    always_comb begin
        out_valid_d = w_pop_any;
        out_id_d    = out_id_q;
        out_data_d  = out_data_q;
        if (w_pop_any) begin
            out_id_d   = w_pop_id;
            out_data_d = w_pop_data;
        end
        // A fresh error event takes priority over a clear in the same cycle.
        err_spur_d  = w_spurious  | (err_spur_q  & ~clr_err);
        err_multi_d = w_multi_hot | (err_multi_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_data_q  <= '0;
            err_spur_q  <= 1'b0;
            err_multi_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_data_q  <= out_data_d;
            err_spur_q  <= err_spur_d;
            err_multi_q <= err_multi_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_id       = out_id_q;
    assign out_data     = out_data_q;
    assign err_spurious = err_spur_q;
    assign err_multi    = err_multi_q;

    // Occupancy is exported by each queue for observability; the top only
    // needs the full/empty decodes.
    logic w_unused_counts;
    assign w_unused_counts = ^w_counts;

endmodule : ah_arb_requester
`default_nettype wire

// File: tb/tb_ah_arb_requester.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ah_arb_requester
//  Description : Self-checking bench for ah_arb_requester. A queue-based
//                reference model predicts req/in_ready, issued commands and
//                error flags for directed scenarios and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ah_arb_requester;

    localparam int NC = 4;
    localparam int DW = 8;
    localparam int DP = 4;

    logic           clk;
    logic           rst_n;
    logic [NC-1:0]  in_valid;
    logic [NC-1:0]  in_ready;
    logic [NC*DW-1:0] in_data;
    logic [NC-1:0]  req;
    logic [NC-1:0]  gnt;
    logic           out_valid;
    logic [1:0]     out_id;
    logic [DW-1:0]  out_data;
    logic           err_spurious;
    logic           err_multi;
    logic           clr_err;

    ah_arb_requester #(
        .NUM_CLIENTS (NC),
        .DATA_W      (DW),
        .DEPTH       (DP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .req          (req),
        .gnt          (gnt),
        .out_valid    (out_valid),
        .out_id       (out_id),
        .out_data     (out_data),
        .err_spurious (err_spurious),
        .err_multi    (err_multi),
        .clr_err      (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [DW-1:0] mq [NC][$];
    logic          e_ov;
    logic [1:0]    e_id;
    logic [DW-1:0] e_dat;
    logic          e_es;
    logic          e_em;

    int n_cmp;
    int n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [NC-1:0] e_req;
        logic [NC-1:0] e_rdy;
        for (int i = 0; i < NC; i++) begin
            e_req[i] = (mq[i].size() > 0);
            e_rdy[i] = (mq[i].size() < DP);
        end
        chk({tag, "_req"},      32'(req),          32'(e_req));
        chk({tag, "_in_ready"}, 32'(in_ready),     32'(e_rdy));
        chk({tag, "_out_valid"},32'(out_valid),    32'(e_ov));
        chk({tag, "_out_id"},   32'(out_id),       32'(e_id));
        chk({tag, "_out_data"}, 32'(out_data),     32'(e_dat));
        chk({tag, "_err_spur"}, 32'(err_spurious), 32'(e_es));
        chk({tag, "_err_multi"},32'(err_multi),    32'(e_em));
    endtask

    task automatic idle_inputs();
        in_valid = '0;
        in_data  = '0;
        gnt      = '0;
        clr_err  = 1'b0;
    endtask

    // Predict one clock from the current inputs and model state, then clock
    // the DUT and compare everything just after the edge.
    task automatic cycle(input string tag);
        int      cnt;
        int      k;
        bit      spur;
        bit      pp;
        bit [NC-1:0] pushf;
        cnt  = 0;
        k    = 0;
        spur = 1'b0;
        for (int i = 0; i < NC; i++) begin
            pushf[i] = in_valid[i] && (mq[i].size() < DP);
            if (gnt[i]) begin
                cnt++;
                k = i;
                if (mq[i].size() == 0) spur = 1'b1;
            end
        end
        pp   = (cnt == 1) && !spur;
        e_ov = pp;
        if (pp) begin
            e_id  = 2'(k);
            e_dat = mq[k].pop_front();
        end
        for (int i = 0; i < NC; i++) begin
            if (pushf[i]) mq[i].push_back(in_data[i*DW +: DW]);
        end
        e_es = spur      ? 1'b1 : (clr_err ? 1'b0 : e_es);
        e_em = (cnt > 1) ? 1'b1 : (clr_err ? 1'b0 : e_em);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic apply_reset(input string tag);
        idle_inputs();
        rst_n = 1'b0;
        for (int i = 0; i < NC; i++) mq[i].delete();
        e_ov  = 1'b0;
        e_id  = '0;
        e_dat = '0;
        e_es  = 1'b0;
        e_em  = 1'b0;
        #1;
        check_all({tag, "_in_rst"});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic push_one(input int c, input logic [DW-1:0] d, input string tag);
        idle_inputs();
        in_valid[c]         = 1'b1;
        in_data[c*DW +: DW] = d;
        cycle(tag);
    endtask

    task automatic grant_one(input int c, input string tag);
        idle_inputs();
        gnt[c] = 1'b1;
        cycle(tag);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        idle_inputs();
        rst_n = 1'b1;
        #2;

        // Reset state
        apply_reset("rst0");
        idle_inputs();
        cycle("rst0_idle");

        // Single command on client 2
        push_one(2, 8'hA5, "c2_push");
        chk("c2_req_set", 32'(req), 32'h4);
        grant_one(2, "c2_gnt");
        chk("c2_ov", 32'(out_valid), 32'h1);
        chk("c2_id", 32'(out_id), 32'h2);
        chk("c2_dat", 32'(out_data), 32'hA5);
        idle_inputs();
        cycle("c2_after");
        chk("c2_req_clr", 32'(req[2]), 32'h0);

        // Fill client 0, offer a fifth entry, drain with separated grants
        for (int j = 0; j < 4; j++) push_one(0, 8'(8'h11 + j), "c0_fill");
        chk("c0_full", 32'(in_ready[0]), 32'h0);
        push_one(0, 8'h99, "c0_overflow");
        for (int j = 0; j < 4; j++) begin
            grant_one(0, "c0_drain");
            chk("c0_order", 32'(out_data), 32'(8'h11 + j));
            idle_inputs();
            cycle("c0_gap");
        end
        chk("c0_empty", 32'(req[0]), 32'h0);

        // Simultaneous push and pop on client 1
        push_one(1, 8'h21, "c1_p1");
        push_one(1, 8'h22, "c1_p2");
        idle_inputs();
        in_valid[1]      = 1'b1;
        in_data[DW +: DW] = 8'h23;
        gnt[1]           = 1'b1;
        cycle("c1_pushpop");
        chk("c1_oldest", 32'(out_data), 32'h21);
        for (int j = 0; j < 2; j++) begin
            grant_one(1, "c1_drain");
            idle_inputs();
            cycle("c1_gap");
        end

        // Spurious grant, sticky flag, clear, clear colliding with new event
        grant_one(3, "sp_evt");
        chk("sp_set", 32'(err_spurious), 32'h1);
        idle_inputs();
        cycle("sp_sticky");
        clr_err = 1'b1;
        cycle("sp_clr");
        chk("sp_cleared", 32'(err_spurious), 32'h0);
        idle_inputs();
        clr_err = 1'b1;
        gnt     = 4'b1000;
        cycle("sp_clr_vs_evt");
        chk("sp_wins", 32'(err_spurious), 32'h1);

        // Multi-hot grant on two requesting clients
        idle_inputs();
        clr_err = 1'b1;
        cycle("mh_clr");
        idle_inputs();
        in_valid = 4'b0011;
        in_data  = 32'h0000_4131;
        cycle("mh_load");
        idle_inputs();
        gnt = 4'b0011;
        cycle("mh_evt");
        chk("mh_flag", 32'(err_multi), 32'h1);
        chk("mh_nopop", 32'(req), 32'h3);
        grant_one(0, "mh_drain0");
        idle_inputs();
        cycle("mh_gap");
        grant_one(1, "mh_drain1");

        // Multi-hot including a non-requesting client sets both flags
        idle_inputs();
        clr_err = 1'b1;
        cycle("mh2_clr");
        push_one(2, 8'h5A, "mh2_load");
        idle_inputs();
        gnt = 4'b0110;
        cycle("mh2_evt");
        grant_one(2, "mh2_drain");

        // Mid-stream reset discards everything
        for (int j = 0; j < 3; j++) begin
            idle_inputs();
            in_valid = 4'b1111;
            in_data  = $urandom;
            cycle("rs_load");
        end
        apply_reset("rs_mid");
        idle_inputs();
        for (int j = 0; j < 4; j++) cycle("rs_after");
        chk("rs_ready", 32'(in_ready), 32'hF);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            int r;
            int c;
            idle_inputs();
            in_valid = 4'($urandom);
            in_data  = $urandom;
            clr_err  = ($urandom_range(0, 7) == 0);
            r = $urandom_range(0, 9);
            c = $urandom_range(0, NC - 1);
            if (r < 6)       gnt = 4'(1 << c);
            else if (r == 6) gnt = 4'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                apply_reset("rnd_rst");
            end else begin
                cycle("rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ah_arb_requester
`default_nettype wire
